// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the core's memory-port arbiter: FSM state,
// bus owner encoding and the instruction returned on an aborted fetch.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  // Fetches are always full 32-bit instruction words.
  localparam logic [2:0]  IF_SIZE  = 3'b010;

  // The remembered owner is OWN_D only when data won while a fetch was also
  // waiting; that is the one case where fetch must win the next contention.
  function automatic owner_e next_last_owner(input owner_e granted, input logic if_pend);
    owner_e res;
    res = OWN_IF;
    if (granted == OWN_D && if_pend) res = OWN_D;
    return res;
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Two-way requester selector: data normally wins, but a fetch that lost the
// previous contention to data wins this one, so the two alternate.
module rr_prio_pick
  import mem_bus_pkg::*;
(
  input  logic   d_pend,
  input  logic   if_pend,
  input  owner_e last_owner,
  output logic   gnt_valid,
  output owner_e gnt_owner
);

  always_comb begin
    gnt_valid = d_pend | if_pend;
    gnt_owner = OWN_IF;
    if (d_pend && !(if_pend && last_owner == OWN_D)) gnt_owner = OWN_D;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction fetch and the load/store port:
// request/grant/response sequencing, alternating arbitration and a hang timeout.
module mem_port_arbiter
  import mem_bus_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_ack,
  output logic [31:0]     if_rdata,
  output logic            if_stall,
  input  logic            d_load,
  input  logic            d_store,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [2:0]      d_size,
  output logic            d_ack,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_stall,
  output logic            d_err,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [2:0]      bus_size,
  input  logic            bus_gnt,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata
);

  // Counter value seen in the last permitted waiting cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  owner_e           owner_q, owner_d;
  owner_e           last_owner_q, last_owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             discard_q, discard_d;
  logic             we_q, we_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic [2:0]       size_q, size_d;

  logic             d_pend;
  logic             pick_valid;
  owner_e           pick_owner;
  logic             done;
  logic             abort;
  logic             finish;

  assign d_pend = d_load | d_store;

  rr_prio_pick u_pick (
    .d_pend     (d_pend),
    .if_pend    (if_req),
    .last_owner (last_owner_q),
    .gnt_valid  (pick_valid),
    .gnt_owner  (pick_owner)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    discard_d    = discard_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    done         = 1'b0;
    abort        = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        discard_d = 1'b0;
        if (pick_valid) begin
          state_d      = REQ;
          owner_d      = pick_owner;
          last_owner_d = next_last_owner(pick_owner, if_req);
          if (pick_owner == OWN_D) begin
            we_d    = d_store;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            size_d  = d_size;
          end else begin
            we_d    = 1'b0;
            addr_d  = if_addr;
            wdata_d = '0;
            size_d  = IF_SIZE;
          end
        end
      end
      REQ: begin
        // A grant on the final allowed cycle still wins over the timeout.
        if (bus_gnt) begin
          state_d = RESP;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (bus_rvalid) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A flushed fetch still finishes on the bus; its ack is swallowed.
    if (state_q != IDLE && owner_q == OWN_IF && !if_req) discard_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_IF;
      cnt_q        <= '0;
      discard_q    <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      discard_q    <= discard_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
    end
  end

  assign finish   = (done | abort) & ~reset;
  assign if_ack   = finish & (owner_q == OWN_IF) & if_req & ~discard_q;
  assign if_rdata = (if_ack & done) ? bus_rdata[31:0] : NOP_INST;
  assign d_ack    = finish & (owner_q == OWN_D);
  assign d_err    = d_ack & abort;
  assign d_rdata  = (d_ack & done & ~we_q) ? bus_rdata : '0;
  assign if_stall = if_req & ~if_ack;
  assign d_stall  = d_pend & ~d_ack;

  assign bus_req   = (state_q == REQ);
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_size  = size_q;

  a_no_gnt_with_rvalid: assert property (@(posedge clock) disable iff (reset)
    !(state_q == REQ && bus_gnt && bus_rvalid));

  a_data_held: assert property (@(posedge clock) disable iff (reset)
    (state_q != IDLE && owner_q == OWN_D) |-> (d_load | d_store));

  a_load_store_excl: assert property (@(posedge clock) disable iff (reset)
    !(d_load && d_store));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-timeline model
// that predicts owners, ack cycles, data and timeouts from the bus delays it picks.
module tb_mem_port_arbiter;

  localparam int XLEN    = 64;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam int NCYC    = 4000;

  logic            clock = 1'b0;
  logic            reset;
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_ack;
  logic [31:0]     if_rdata;
  logic            if_stall;
  logic            d_load;
  logic            d_store;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic [2:0]      d_size;
  logic            d_ack;
  logic [XLEN-1:0] d_rdata;
  logic            d_stall;
  logic            d_err;
  logic            bus_req;
  logic            bus_we;
  logic [XLEN-1:0] bus_addr;
  logic [XLEN-1:0] bus_wdata;
  logic [2:0]      bus_size;
  logic            bus_gnt;
  logic            bus_rvalid;
  logic [XLEN-1:0] bus_rdata;

  mem_port_arbiter #(.XLEN(XLEN), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_load(d_load), .d_store(d_store), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall), .d_err(d_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_size(bus_size), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = -1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, act, exp);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    bit f_req, f_acked, d_acked, act, own_d, m_we, ab, ab_req, m_last;
    bit wdrawn, stale_rv, did_rst, rst_now, e_breq, fin, e_iack, e_dack, e_derr;
    int d_kind, t0, tg, tend, t_rv, g, r;
    logic [63:0] f_addr, d_a, d_w, m_addr, m_wdata;
    logic [2:0] d_sz, m_size;

    f_req = 1'b1; f_addr = 64'h0000_0000_8000_0000;
    d_kind = 1; d_a = 64'h1000; d_w = '0; d_sz = 3'b011;
    f_acked = 1'b0; d_acked = 1'b0; act = 1'b0; m_last = 1'b0; stale_rv = 1'b0; did_rst = 1'b0;
    t0 = 0; tg = 0; tend = 0; t_rv = -1; own_d = 1'b0; m_we = 1'b0; ab = 1'b0; ab_req = 1'b0;

    reset = 1'b1;
    if_req = f_req; if_addr = f_addr;
    d_load = 1'b1; d_store = 1'b0; d_addr = d_a; d_wdata = d_w; d_size = d_sz;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    @(negedge clock);
    @(negedge clock);
    #1;
    check_eq("rst_ctl", {if_ack, if_stall, d_ack, d_err, d_stall, bus_req}, 6'b010010);
    check_eq("rst_bus", {bus_we, bus_size}, 4'b0000);
    check_eq("rst_addr", bus_addr, 64'h0);
    check_eq("rst_wdata", bus_wdata, 64'h0);
    check_eq("rst_rdata", {if_rdata, d_rdata}, 96'h0);

    for (int i = 0; i < NCYC; i++) begin
      @(negedge clock);
      cyc = i;

      // Requesters: fetch may flush at any time; data holds until its ack.
      if (f_acked) begin
        f_req  = ($urandom % 3) != 0;
        f_addr = rnd64() & ~64'h3;
      end else if (!f_req) begin
        if ($urandom % 4 == 0) begin
          f_req  = 1'b1;
          f_addr = rnd64() & ~64'h3;
        end
      end else if ($urandom % 12 == 0) begin
        f_req = 1'b0;
      end
      if (d_acked) d_kind = 0;
      if (d_kind == 0 && $urandom % 3 == 0) begin
        d_kind = 1 + int'($urandom % 2);
        d_a    = rnd64() & ~64'h7;
        d_w    = rnd64();
        d_sz   = 3'($urandom);
      end
      if_req  = f_req;
      if_addr = f_addr;
      d_load  = (d_kind == 1);
      d_store = (d_kind == 2);
      d_addr  = d_a;
      d_wdata = d_w;
      d_size  = d_sz;
      bus_rdata = rnd64();

      rst_now = act && !ab_req && i > tg && i < tend &&
                ((!did_rst && i > 300) || ($urandom % 32 == 0));
      if (rst_now) begin
        reset = 1'b1; bus_gnt = 1'b0; bus_rvalid = 1'b0;
        #1;
        check_eq("rst_mid", {if_ack, if_stall, d_ack, d_err, d_stall, bus_req},
                 {1'b0, f_req, 1'b0, 1'b0, d_kind != 0, 1'b0});
        act = 1'b0; m_last = 1'b0; stale_rv = 1'b1; did_rst = 1'b1;
        f_acked = 1'b0; d_acked = 1'b0;
        continue;
      end
      reset = 1'b0;

      bus_rvalid = stale_rv || (!act && $urandom % 12 == 0);
      stale_rv   = 1'b0;

      if (!act && (f_req || d_kind != 0)) begin
        t0     = i;
        own_d  = (d_kind != 0) && !(f_req && m_last);
        m_last = own_d && f_req;
        m_we   = own_d && (d_kind == 2);
        m_addr = own_d ? d_a : f_addr;
        m_wdata = d_w;
        m_size = d_sz;
        g = ($urandom % 8 == 0) ? TIMEOUT : int'($urandom_range(0, TIMEOUT - 1));
        r = ($urandom % 8 == 0) ? TIMEOUT : int'($urandom_range(0, TIMEOUT - 1));
        wdrawn = 1'b0;
        act    = 1'b1;
        if (g >= TIMEOUT) begin
          ab_req = 1'b1; ab = 1'b1; tg = t0 + TIMEOUT; tend = tg; t_rv = -1;
        end else begin
          ab_req = 1'b0; tg = t0 + 1 + g;
          if (r >= TIMEOUT) begin
            ab = 1'b1; tend = tg + TIMEOUT; t_rv = -1;
          end else begin
            ab = 1'b0; tend = tg + 1 + r; t_rv = tend;
          end
        end
      end

      bus_gnt = act && !ab_req && i == tg;
      if (act && i == t_rv) bus_rvalid = 1'b1;
      if (act && !own_d && i > t0 && !f_req) wdrawn = 1'b1;

      e_breq = act && i > t0 && i <= tg;
      fin    = act && i == tend;
      e_iack = fin && !own_d && !wdrawn;
      e_dack = fin && own_d;
      e_derr = e_dack && ab;

      #1;
      check_eq("ctl", {if_ack, if_stall, d_ack, d_err, d_stall, bus_req},
               {e_iack, f_req && !e_iack, e_dack, e_derr, (d_kind != 0) && !e_dack, e_breq});
      if (e_iack) check_eq("if_rdata", if_rdata, ab ? 32'h0 : bus_rdata[31:0]);
      if (e_dack) check_eq("d_rdata", d_rdata, (ab || m_we) ? 64'h0 : bus_rdata);
      if (e_breq) begin
        check_eq("bus_addr", bus_addr, m_addr);
        check_eq("bus_we", bus_we, m_we);
        if (own_d) check_eq("bus_size", bus_size, m_size);
        if (m_we) check_eq("bus_wdata", bus_wdata, m_wdata);
      end

      f_acked = e_iack;
      d_acked = e_dack;
      if (fin) act = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
